regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/lc3_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Brief    : Shared types for the LC-3 writeback path
// Revision : 1.0
// ============================================================================
package lc3_pkg;

    localparam int C_REG_ADDR_W = 3;
    localparam int C_WORD_W     = 16;

    typedef logic [C_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [C_WORD_W-1:0]     word_t;

    // Names the requester that wins when both ask in the same cycle
    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_state_t;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter with one-hot grants
// Revision : 1.0
// ============================================================================
module rr_arb2
    import lc3_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    pri_state_t r_state;
    pri_state_t w_state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= PRI_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are suppressed during reset so nothing is accepted that would be dropped
    always_comb begin
        w_state_next = r_state;
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        if (!reset) begin
            gnt_a = req_a && (!req_b || (r_state == PRI_A));
            gnt_b = req_b && (!req_a || (r_state == PRI_B));
        end
        if (gnt_a) begin
            w_state_next = PRI_B;
        end else if (gnt_b) begin
            w_state_next = PRI_A;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Arbitrates ALU/load writebacks into the register file, tracks pending writes
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  reg_addr_t         a_dr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  reg_addr_t         b_dr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  reg_addr_t         issue_dr,
    output logic              rf_wr,
    output reg_addr_t         rf_dr,
    output logic [DATA_W-1:0] rf_din,
    output logic [REG_N-1:0]  busy
);

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              r_rf_wr;
    reg_addr_t         r_rf_dr;
    logic [DATA_W-1:0] r_rf_din;
    logic [REG_N-1:0]  r_busy;
    logic [REG_N-1:0]  w_set;
    logic [REG_N-1:0]  w_clr;

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (w_gnt_a),
        .gnt_b (w_gnt_b)
    );

    assign a_ready = w_gnt_a;
    assign b_ready = w_gnt_b;

    // Clear tracks the write being committed now; set is applied last so it wins
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid) begin
            w_set[issue_dr] = 1'b1;
        end
        if (r_rf_wr) begin
            w_clr[r_rf_dr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_wr  <= 1'b0;
            r_rf_dr  <= '0;
            r_rf_din <= '0;
            r_busy   <= '0;
        end else begin
            r_rf_wr <= w_gnt_a || w_gnt_b;
            if (w_gnt_a) begin
                r_rf_dr  <= a_dr;
                r_rf_din <= a_data;
            end else if (w_gnt_b) begin
                r_rf_dr  <= b_dr;
                r_rf_din <= b_data;
            end
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign rf_wr  = r_rf_wr;
    assign rf_dr  = r_rf_dr;
    assign rf_din = r_rf_din;
    assign busy   = r_busy;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed and randomized checks of regfile_wb_arbiter against a reference model
// Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, issue_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_dr, b_dr, issue_dr;
    logic [15:0] a_data, b_data;
    logic        rf_wr;
    logic [2:0]  rf_dr;
    logic [15:0] rf_din;
    logic [7:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.DATA_W(16), .REG_N(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_dr        (a_dr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_dr        (b_dr),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_dr    (issue_dr),
        .rf_wr       (rf_wr),
        .rf_dr       (rf_dr),
        .rf_din      (rf_din),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Reference model: who won last, what was written last, which registers are pending
    bit          m_ok = 0;
    bit          m_fav_a;
    bit          m_wr;
    bit [2:0]    m_dr;
    bit [15:0]   m_din;
    bit          m_pend[8];

    initial begin
        bit s_rst, s_av, s_bv, s_iv, ga, gb, ea, eb;
        bit [2:0]  s_adr, s_bdr, s_idr;
        bit [15:0] s_ad, s_bd;
        bit [7:0]  m_busy;
        forever begin
            @(negedge clock);
            if (m_ok) begin
                ea = !reset && a_valid && (!b_valid || m_fav_a);
                eb = !reset && b_valid && (!a_valid || !m_fav_a);
                for (int i = 0; i < 8; i++) m_busy[i] = m_pend[i];
                check("model_a_ready", a_ready, ea);
                check("model_b_ready", b_ready, eb);
                check("model_rf_wr", rf_wr, m_wr);
                check("model_rf_dr", rf_dr, m_dr);
                check("model_rf_din", rf_din, m_din);
                check("model_busy", busy, m_busy);
            end
            s_rst = reset;    s_av = a_valid;  s_bv = b_valid; s_iv = issue_valid;
            s_adr = a_dr;     s_bdr = b_dr;    s_idr = issue_dr;
            s_ad  = a_data;   s_bd  = b_data;
            @(posedge clock);
            if (s_rst) begin
                m_ok = 1; m_fav_a = 1; m_wr = 0; m_dr = 0; m_din = 0;
                for (int i = 0; i < 8; i++) m_pend[i] = 0;
            end else begin
                ga = s_av && (!s_bv || m_fav_a);
                gb = s_bv && !ga;
                if (m_wr) m_pend[m_dr] = 0;
                if (s_iv) m_pend[s_idr] = 1;
                m_wr = ga || gb;
                if (ga) begin
                    m_dr = s_adr; m_din = s_ad; m_fav_a = 0;
                end else if (gb) begin
                    m_dr = s_bdr; m_din = s_bd; m_fav_a = 1;
                end
            end
        end
    end

    initial begin
        bit pend_a, pend_b;
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; issue_valid = 1'b1; issue_dr = 3'd2;
        a_dr = 3'd6; b_dr = 3'd5; a_data = 16'h0; b_data = 16'h0;
        cyc(); cyc();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_rf_wr", rf_wr, 0);
        check("rst_rf_dr", rf_dr, 0);
        check("rst_rf_din", rf_din, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;

        // Single request
        a_valid = 1'b1; a_dr = 3'd3; a_data = 16'h1234; #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        cyc(); a_valid = 1'b0;
        check("single_rf_wr", rf_wr, 1);
        check("single_rf_dr", rf_dr, 3);
        check("single_rf_din", rf_din, 16'h1234);
        cyc();
        check("single_idle_wr", rf_wr, 0);
        check("single_hold_din", rf_din, 16'h1234);

        // Tie from reset alternates A,B,A,B
        reset_pulse();
        a_valid = 1'b1; a_dr = 3'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_dr = 3'd2; b_data = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_a_ready", a_ready, (i % 2) == 0);
            cyc();
            check("tie_rf_dr", rf_dr, ((i % 2) == 0) ? 1 : 2);
            check("tie_rf_din", rf_din, ((i % 2) == 0) ? 16'hAAAA : 16'hBBBB);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Scoreboard set then clear on commit
        reset_pulse();
        issue_valid = 1'b1; issue_dr = 3'd5; cyc(); issue_valid = 1'b0;
        check("sb_set", busy, 8'h20);
        cyc(); cyc();
        check("sb_wait", busy, 8'h20);
        a_valid = 1'b1; a_dr = 3'd5; a_data = 16'h5555; cyc(); a_valid = 1'b0;
        check("sb_commit_wr", rf_wr, 1);
        check("sb_commit_busy", busy, 8'h20);
        cyc();
        check("sb_clear", busy, 8'h00);

        // Same-bit collision keeps set; different bits both apply
        issue_valid = 1'b1; issue_dr = 3'd4; cyc(); issue_valid = 1'b0;
        a_valid = 1'b1; a_dr = 3'd4; a_data = 16'h4444; cyc(); a_valid = 1'b0;
        issue_valid = 1'b1; issue_dr = 3'd4; cyc(); issue_valid = 1'b0;
        check("col_same_bit", busy, 8'h10);
        a_valid = 1'b1; a_dr = 3'd4; cyc(); a_valid = 1'b0;
        issue_valid = 1'b1; issue_dr = 3'd1; cyc(); issue_valid = 1'b0;
        check("col_diff_bits", busy, 8'h02);

        // Reset in the grant cycle drops the write
        a_valid = 1'b1; a_dr = 3'd6; a_data = 16'h6666;
        issue_valid = 1'b1; issue_dr = 3'd7; reset = 1'b1; #1;
        check("rm_a_ready", a_ready, 0);
        cyc(); reset = 1'b0; issue_valid = 1'b0;
        b_valid = 1'b1; b_dr = 3'd0; b_data = 16'h0BBB;
        check("rm_rf_wr", rf_wr, 0);
        check("rm_busy", busy, 0);
        #1;
        check("rm_a_ready_again", a_ready, 1);
        check("rm_b_ready", b_ready, 0);
        cyc(); a_valid = 1'b0;
        check("rm_rf_dr", rf_dr, 6);
        cyc(); b_valid = 1'b0;
        check("rm_b_rf_din", rf_din, 16'h0BBB);

        // Back-pressure on A while B is granted
        a_valid = 1'b1; a_dr = 3'd1; a_data = 16'h1111; cyc();
        a_dr = 3'd7; a_data = 16'h7777;
        b_valid = 1'b1; b_dr = 3'd2; b_data = 16'h2222; #1;
        check("bp_a_ready", a_ready, 0);
        check("bp_b_ready", b_ready, 1);
        cyc(); b_valid = 1'b0;
        check("bp_b_rf_dr", rf_dr, 2);
        #1;
        check("bp_a_ready_next", a_ready, 1);
        cyc(); a_valid = 1'b0;
        check("bp_a_rf_dr", rf_dr, 7);
        check("bp_a_rf_din", rf_din, 16'h7777);

        // Randomized traffic obeying the hold-until-ready rule
        for (int n = 0; n < 3000; n++) begin
            #1;
            pend_a = a_valid && !a_ready && !reset;
            pend_b = b_valid && !b_ready && !reset;
            cyc();
            reset = ($urandom_range(0, 99) < 2);
            if (pend_a) begin
                if ($urandom_range(0, 9) == 0) a_valid = 1'b0;
            end else begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_dr    = 3'($urandom_range(0, 7));
                a_data  = 16'($urandom);
            end
            if (pend_b) begin
                if ($urandom_range(0, 9) == 0) b_valid = 1'b0;
            end else begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_dr    = 3'($urandom_range(0, 7));
                b_data  = 16'($urandom);
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_dr    = 3'($urandom_range(0, 7));
        end
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
